// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline control block
package pipeline_ctrl_pkg;

    localparam int REG_W         = 4;
    localparam int SRAM_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational RAW hazard term, forwarding-aware
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             fwd_en,
    output logic             hz
);

    logic exe_s1, exe_s2, mem_s1, mem_s2;

    always_comb begin
        exe_s1 = (exe_dest == src1);
        exe_s2 = two_src && (exe_dest == src2);
        mem_s1 = (mem_dest == src1);
        mem_s2 = two_src && (mem_dest == src2);
        hz     = 1'b0;
        // With forwarding only a load in EXE cannot be bypassed in time.
        if (fwd_en)
            hz = exe_mem_r_en && (exe_s1 || exe_s2);
        else
            hz = (exe_wb_en && (exe_s1 || exe_s2)) || (mem_wb_en && (mem_s1 || mem_s2));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - freeze/flush strobe generation with SRAM wait-state FSM
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT   = SRAM_WAIT_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_W-1:0]       src1,
    input  logic [REG_W-1:0]       src2,
    input  logic                   two_src,
    input  logic [REG_W-1:0]       exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_r_en,
    input  logic [REG_W-1:0]       mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   mem_access,
    input  logic                   fwd_en,
    input  logic                   branch_taken,
    output logic                   freeze_pc,
    output logic                   freeze_id,
    output logic                   bubble_id,
    output logic                   flush_if,
    output logic                   flush_id,
    output logic                   mem_stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] WAIT_LOAD = 4'(SRAM_WAIT - 1);

    state_e                 state_q;
    logic [3:0]             wcnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   hz;

    pipeline_ctrl_hazard_detect u_hazard_detect (
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .fwd_en       (fwd_en),
        .hz           (hz)
    );

    // The first stall cycle is the IDLE cycle that sees the access, so WAIT covers SRAM_WAIT-1.
    always_comb begin
        mem_stall = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && mem_access);
        stall_cnt_d = stall_cnt_q;
        if (mem_stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

    always_comb begin
        freeze_pc = 1'b0;
        freeze_id = 1'b0;
        bubble_id = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        if (mem_stall) begin
            freeze_pc = 1'b1;
            freeze_id = 1'b1;
        end else if (branch_taken) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (hz) begin
            freeze_pc = 1'b1;
            freeze_id = 1'b1;
            bubble_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (mem_access) begin
                        wcnt_q  <= WAIT_LOAD;
                        state_q <= (WAIT_LOAD == 4'd0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wcnt_q <= wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1)
                        state_q <= ST_DONE;
                end
                // An access still visible here belongs to the instruction now leaving MEM.
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int SW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_access, fwd_en, branch_taken;

    logic        a_fpc, a_fid, a_bub, a_fif, a_fidf, a_ms;
    logic [15:0] a_cnt;
    logic        b_fpc, b_fid, b_bub, b_fif, b_fidf, b_ms;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.SRAM_WAIT(SW), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
        .fwd_en(fwd_en), .branch_taken(branch_taken),
        .freeze_pc(a_fpc), .freeze_id(a_fid), .bubble_id(a_bub), .flush_if(a_fif),
        .flush_id(a_fidf), .mem_stall(a_ms), .stall_cnt(a_cnt)
    );

    pipeline_ctrl #(.SRAM_WAIT(SW), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
        .fwd_en(fwd_en), .branch_taken(branch_taken),
        .freeze_pc(b_fpc), .freeze_id(b_fid), .bubble_id(b_bub), .flush_if(b_fif),
        .flush_id(b_fidf), .mem_stall(b_ms), .stall_cnt(b_cnt)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining stall cycles after the current one, plus a one-cycle release flag.
    int m_rem   = 0;
    bit m_done  = 1'b0;
    int m_cnt_a = 0;
    int m_cnt_b = 0;
    bit check_en = 1'b0;

    function automatic bit m_stall();
        return (m_rem > 0) || (!m_done && (mem_access === 1'b1));
    endfunction

    function automatic bit m_hz();
        int d_e, d_m, s1, s2;
        bit r1, r2;
        d_e = int'(exe_dest); d_m = int'(mem_dest); s1 = int'(src1); s2 = int'(src2);
        if (fwd_en)
            return exe_mem_r_en && ((d_e == s1) || (two_src && (d_e == s2)));
        r1 = (exe_wb_en && (d_e == s1)) || (mem_wb_en && (d_m == s1));
        r2 = (exe_wb_en && (d_e == s2)) || (mem_wb_en && (d_m == s2));
        return r1 || (two_src && r2);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_rem    <= 0;
            m_done   <= 1'b0;
            m_cnt_a  <= 0;
            m_cnt_b  <= 0;
            check_en <= 1'b1;
        end else begin
            if (m_stall()) begin
                m_cnt_a <= (m_cnt_a == 65535) ? 65535 : m_cnt_a + 1;
                m_cnt_b <= (m_cnt_b == 15) ? 15 : m_cnt_b + 1;
            end
            if (m_rem > 0) begin
                m_rem  <= m_rem - 1;
                m_done <= (m_rem == 1);
            end else if (m_done) begin
                m_done <= 1'b0;
            end else if (mem_access) begin
                m_rem  <= SW - 1;
                m_done <= (SW == 1);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit st, hz, e_frz, e_bub, e_fl;
            st    = m_stall();
            hz    = m_hz();
            e_frz = st || (!branch_taken && hz);
            e_bub = !st && !branch_taken && hz;
            e_fl  = !st && branch_taken;
            chk1("mem_stall", a_ms, st);
            chk1("freeze_pc", a_fpc, e_frz);
            chk1("freeze_id", a_fid, e_frz);
            chk1("bubble_id", a_bub, e_bub);
            chk1("flush_if", a_fif, e_fl);
            chk1("flush_id", a_fidf, e_fl);
            chkn("stall_cnt", int'(a_cnt), m_cnt_a);
            chk1("sat_mem_stall", b_ms, st);
            chk1("sat_freeze_pc", b_fpc, e_frz);
            chk1("sat_bubble_id", b_bub, e_bub);
            chk1("sat_flush_if", b_fif, e_fl);
            chk1("sat_flush_id", b_fidf, e_fl);
            chk1("sat_freeze_id", b_fid, e_frz);
            chkn("sat_stall_cnt", int'(b_cnt), m_cnt_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; src1 = 4'd0; src2 = 4'd0; two_src = 1'b0; exe_dest = 4'd0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = 4'd0; mem_wb_en = 1'b0;
        mem_access = 1'b1; fwd_en = 1'b0; branch_taken = 1'b0;

        tick(); tick(); #1;
        chk1("lit_rst_stall", a_ms, 1'b1);
        chkn("lit_rst_cnt", int'(a_cnt), 0);

        rst = 1'b1;
        tick();
        mem_access = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk1("lit_wait_stall", a_ms, 1'b1);
            tick();
        end
        #1;
        chk1("lit_done_stall", a_ms, 1'b0);
        chkn("lit_cnt4", int'(a_cnt), 4);
        tick();

        fwd_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 4'd3; src1 = 4'd3; #1;
        chk1("lit_raw_fpc", a_fpc, 1'b1);
        chk1("lit_raw_bub", a_bub, 1'b1);
        two_src = 1'b0; src2 = 4'd3; src1 = 4'd4; #1;
        chk1("lit_noraw_fpc", a_fpc, 1'b0);
        chk1("lit_noraw_bub", a_bub, 1'b0);

        fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd5; two_src = 1'b1; src2 = 4'd5; src1 = 4'd0; #1;
        chk1("lit_ldu_bub", a_bub, 1'b1);
        exe_mem_r_en = 1'b0; #1;
        chk1("lit_fwd_nofrz", a_fpc, 1'b0);

        exe_mem_r_en = 1'b1; branch_taken = 1'b1; mem_access = 1'b1; #1;
        chk1("lit_br_stall_fif", a_fif, 1'b0);
        chk1("lit_br_stall_bub", a_bub, 1'b0);
        tick();
        mem_access = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk1("lit_br_wait_fid", a_fidf, 1'b0);
            tick();
        end
        #1;
        chk1("lit_br_done_fif", a_fif, 1'b1);
        chk1("lit_br_done_fid", a_fidf, 1'b1);
        chk1("lit_br_done_bub", a_bub, 1'b0);
        branch_taken = 1'b0; exe_mem_r_en = 1'b0;

        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_access = 1'b1;
            tick();
            mem_access = 1'b0;
            tick(); tick(); tick(); tick();
        end
        #1;
        chkn("lit_sat_cnt", int'(b_cnt), 15);
        chkn("lit_wide_cnt", int'(a_cnt), 20);

        for (int n = 0; n < 3000; n++) begin
            tick();
            rst          = ($urandom_range(0, 49) != 0);
            src1         = 4'($urandom_range(0, 3));
            src2         = 4'($urandom_range(0, 3));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            two_src      = 1'($urandom_range(0, 1));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            fwd_en       = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 4) == 0);
            mem_access   = ($urandom_range(0, 3) == 0);
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
